// File: rtl/irq_sched.sv
// irq_sched: fixed-priority interrupt entry sequencer (hold, return-PC push, vector override).
// Define IRQ_NEST_EN to allow a higher-priority line to preempt a line in service.
module irq_sched #(
  parameter int         NIRQ     = 4,
  parameter logic [9:0] VEC_BASE = 10'h3C0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wd,
  input  logic            ie_set,
  input  logic            ie_clr,
  input  logic            fetch_ok,
  input  logic            reti,
  input  logic [9:0]      pc_cur,
  output logic            hold,
  output logic            push,
  output logic [9:0]      push_data,
  output logic            vec_sel,
  output logic [9:0]      vec_addr,
  output logic [NIRQ-1:0] ack,
  output logic [NIRQ-1:0] in_service,
  output logic            ie
);
  localparam int IW = NIRQ > 1 ? $clog2(NIRQ) : 1;
  typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;
  state_t          state_q, state_d;
  logic [NIRQ-1:0] irq_q, pending_q, pending_d, mask_q, mask_d, insvc_q, insvc_d;
  logic [NIRQ-1:0] cand_m, cur_oh, svc_low;
  logic [IW-1:0]   cur_q, cur_d, cand_idx;
  logic            cand_v, ie_q, ie_d;
`ifdef IRQ_NEST_EN
  logic [NIRQ-1:0] cand_oh;
  assign cand_oh = cand_m & (~cand_m + NIRQ'(1));
`endif
  assign cand_m  = pending_q & mask_q;
  assign cand_v  = |cand_m;
  assign cur_oh  = NIRQ'(1) << cur_q;
  assign svc_low = insvc_q & (~insvc_q + NIRQ'(1));
  always_comb begin
    cand_idx = '0;
    for (int i = NIRQ - 1; i >= 0; i--)
      if (cand_m[i]) cand_idx = IW'(i);
  end
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    mask_d    = mask_we ? mask_wd : mask_q;
    pending_d = pending_q;
    insvc_d   = insvc_q;
    ie_d      = ie_q | ie_set;
    case (state_q)
      IDLE:
        if (ie_q && cand_v && fetch_ok) begin
          state_d = TAKE;
          cur_d   = cand_idx;
        end
      TAKE: begin
        state_d   = SERVICE;
        pending_d = pending_q & ~cur_oh;
        insvc_d   = insvc_q | cur_oh;
`ifndef IRQ_NEST_EN
        ie_d      = 1'b0;
`endif
      end
      SERVICE:
        if (reti) begin
          insvc_d = insvc_q & ~svc_low;
          if (insvc_d == '0) begin
            state_d = IDLE;
`ifndef IRQ_NEST_EN
            ie_d    = 1'b1;
`endif
          end
        end
`ifdef IRQ_NEST_EN
        else if (ie_q && fetch_ok && cand_v && cand_oh < svc_low) begin
          state_d = TAKE;
          cur_d   = cand_idx;
        end
`endif
      default: state_d = IDLE;
    endcase
    // a new edge re-pends even when the same line is being cleared
    pending_d = pending_d | (irq & ~irq_q);
    if (ie_clr) ie_d = 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      insvc_q   <= '0;
      ie_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      irq_q     <= irq;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      insvc_q   <= insvc_d;
      ie_q      <= ie_d;
    end
  assign hold       = state_q == TAKE;
  assign push       = hold;
  assign vec_sel    = hold;
  assign push_data  = pc_cur;
  assign ack        = hold ? cur_oh : '0;
  assign vec_addr   = hold ? VEC_BASE + (10'(cur_q) << 2) : VEC_BASE;
  assign in_service = insvc_q;
  assign ie         = ie_q;
endmodule

// File: tb/tb_irq_sched.sv
// tb_irq_sched: scoreboard bench for irq_sched; each expected take is queued before its stimulus.
module tb_irq_sched;
  logic       clk = 0, reset = 1;
  logic [3:0] irq = 0, mask_wd = 0, ack, in_service;
  logic       mask_we = 0, ie_set = 0, ie_clr = 0, fetch_ok = 1, reti = 0;
  logic [9:0] pc_cur = 10'h123, push_data, vec_addr;
  logic       hold, push, vec_sel, ie;
  logic [23:0] sb[$];
  logic [23:0] e;
  int checks = 0, failures = 0;
`ifdef IRQ_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif
  irq_sched dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_wd(mask_wd),
    .ie_set(ie_set), .ie_clr(ie_clr), .fetch_ok(fetch_ok), .reti(reti), .pc_cur(pc_cur),
    .hold(hold), .push(push), .push_data(push_data), .vec_sel(vec_sel), .vec_addr(vec_addr),
    .ack(ack), .in_service(in_service), .ie(ie)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (push) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_take ack=%b vec_addr=%h", ack, vec_addr);
      end else begin
        e = sb.pop_front();
        if ({push_data, vec_addr, ack} !== e || hold !== 1'b1 || vec_sel !== 1'b1) begin
          failures++;
          $display("FAIL take got pc=%h vec=%h ack=%b hold=%b vec_sel=%b want pc=%h vec=%h ack=%b",
                   push_data, vec_addr, ack, hold, vec_sel, e[23:14], e[13:4], e[3:0]);
        end
      end
    end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic test_reset();
    step();
    step();
    checks++;
    if ({hold, push, vec_sel, ack, in_service, ie, vec_addr, push_data} !== {3'b000, 4'h0, 4'h0, 1'b0, 10'h3C0, 10'h123}) begin
      failures++;
      $display("FAIL reset_state got hold=%b push=%b vec_sel=%b ack=%b insvc=%b ie=%b vec=%h pd=%h",
               hold, push, vec_sel, ack, in_service, ie, vec_addr, push_data);
    end
    reset = 0;
    step();
  endtask
  task automatic test_ie();
    ie_set = 1; ie_clr = 1;
    step();
    checks++;
    if (ie !== 1'b0) begin failures++; $display("FAIL ie_clr_wins got %b want 0", ie); end
    ie_clr = 0;
    step();
    ie_set = 0;
    checks++;
    if (ie !== 1'b1) begin failures++; $display("FAIL ie_set got %b want 1", ie); end
    reti = 1;
    step();
    reti = 0;
    checks++;
    if ({ie, in_service, hold} !== {1'b1, 4'h0, 1'b0}) begin
      failures++;
      $display("FAIL idle_reti got ie=%b insvc=%b hold=%b want 1 0000 0", ie, in_service, hold);
    end
    ie_clr = 1;
    step();
    ie_clr = 0;
  endtask
  task automatic test_single();
    mask_we = 1; mask_wd = 4'hF; ie_set = 1;
    step();
    mask_we = 0; ie_set = 0; pc_cur = 10'h045;
    sb.push_back({10'h045, 10'h3C8, 4'b0100});
    irq = 4'b0100;
    step();
    irq = 0;
    checks++;
    if (hold !== 1'b0) begin failures++; $display("FAIL single_early got hold=%b want 0", hold); end
    step();
    checks++;
    if (hold !== 1'b1) begin failures++; $display("FAIL single_latency got hold=%b want 1", hold); end
    step();
    checks++;
    if ({in_service, ie, hold} !== {4'b0100, NEST, 1'b0}) begin
      failures++;
      $display("FAIL single_service got insvc=%b ie=%b hold=%b want 0100 %b 0", in_service, ie, hold, NEST);
    end
    reti = 1;
    step();
    reti = 0;
    checks++;
    if ({in_service, ie} !== {4'b0000, 1'b1}) begin
      failures++;
      $display("FAIL single_reti got insvc=%b ie=%b want 0000 1", in_service, ie);
    end
  endtask
  task automatic test_priority();
    pc_cur = 10'h100;
    sb.push_back({10'h100, 10'h3C4, 4'b0010});
    sb.push_back({10'h100, 10'h3CC, 4'b1000});
    irq = 4'b1010;
    step();
    irq = 0;
    for (int k = 0; k < 10 && sb.size() > 1; k++) step();
    step();
    checks++;
    if (in_service !== 4'b0010) begin failures++; $display("FAIL prio_first got insvc=%b want 0010", in_service); end
    reti = 1;
    step();
    reti = 0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) step();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL prio_second_timeout got pending=%0d want 0", sb.size()); end
    step();
    checks++;
    if (in_service !== 4'b1000) begin failures++; $display("FAIL prio_second got insvc=%b want 1000", in_service); end
    reti = 1;
    step();
    reti = 0;
  endtask
  task automatic test_mask();
    bit seen = 0;
    mask_we = 1; mask_wd = 4'b1110;
    step();
    mask_we = 0; irq = 4'b0001; pc_cur = 10'h2A0;
    step();
    irq = 0;
    for (int k = 0; k < 6; k++) begin step(); seen |= hold; end
    checks++;
    if (seen) begin failures++; $display("FAIL masked_take got hold=1 want 0"); end
    sb.push_back({10'h2A0, 10'h3C0, 4'b0001});
    mask_we = 1; mask_wd = 4'hF;
    step();
    mask_we = 0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) step();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL unmask_timeout got pending=%0d want 0", sb.size()); end
    step();
    checks++;
    if (in_service !== 4'b0001) begin failures++; $display("FAIL unmask_service got insvc=%b want 0001", in_service); end
    reti = 1;
    step();
    reti = 0;
  endtask
  task automatic test_fetch();
    bit seen = 0;
    fetch_ok = 0; pc_cur = 10'h3FF;
    irq = 4'b0010;
    step();
    irq = 0;
    for (int k = 0; k < 5; k++) begin step(); seen |= hold; end
    checks++;
    if (seen) begin failures++; $display("FAIL fetch_blocked got hold=1 want 0"); end
    sb.push_back({10'h3FF, 10'h3C4, 4'b0010});
    fetch_ok = 1;
    step();
    checks++;
    if (hold !== 1'b1 || sb.size() != 0) begin
      failures++;
      $display("FAIL fetch_release got hold=%b pending=%0d want 1 0", hold, sb.size());
    end
    step();
    reti = 1;
    step();
    reti = 0;
  endtask
  task automatic test_nest();
    bit seen = 0;
    pc_cur = 10'h080;
    sb.push_back({10'h080, 10'h3CC, 4'b1000});
    irq = 4'b1000;
    step();
    irq = 0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) step();
    step();
    pc_cur = 10'h081;
    if (NEST) sb.push_back({10'h081, 10'h3C0, 4'b0001});
    irq = 4'b0001;
    step();
    irq = 0;
    for (int k = 0; k < 5; k++) begin step(); seen |= hold; end
    checks++;
    if (seen !== NEST || sb.size() != 0) begin
      failures++;
      $display("FAIL nest_take got took=%b pending=%0d want %b 0", seen, sb.size(), NEST);
    end
    checks++;
    if (in_service !== (NEST ? 4'b1001 : 4'b1000)) begin
      failures++;
      $display("FAIL nest_insvc got %b want %b", in_service, NEST ? 4'b1001 : 4'b1000);
    end
    if (!NEST) sb.push_back({10'h081, 10'h3C0, 4'b0001});
    reti = 1;
    step();
    reti = 0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) step();
    step();
    checks++;
    if (in_service !== (NEST ? 4'b1000 : 4'b0001)) begin
      failures++;
      $display("FAIL nest_reti1 got %b want %b", in_service, NEST ? 4'b1000 : 4'b0001);
    end
    reti = 1;
    step();
    reti = 0;
    checks++;
    if ({in_service, ie} !== {4'b0000, 1'b1}) begin
      failures++;
      $display("FAIL nest_reti2 got insvc=%b ie=%b want 0000 1", in_service, ie);
    end
  endtask
  task automatic test_reset_take();
    bit seen = 0;
    pc_cur = 10'h155;
    sb.push_back({10'h155, 10'h3C8, 4'b0100});
    irq = 4'b0100;
    step();
    irq = 0;
    step();
    checks++;
    if (hold !== 1'b1) begin failures++; $display("FAIL rst_take_setup got hold=%b want 1", hold); end
    reset = 1;
    #1;
    checks++;
    if ({hold, push, vec_sel, ack, in_service, ie, vec_addr} !== {3'b000, 4'h0, 4'h0, 1'b0, 10'h3C0}) begin
      failures++;
      $display("FAIL rst_take got hold=%b push=%b vec_sel=%b ack=%b insvc=%b ie=%b vec=%h",
               hold, push, vec_sel, ack, in_service, ie, vec_addr);
    end
    step();
    reset = 0;
    for (int k = 0; k < 4; k++) begin step(); seen |= hold; end
    checks++;
    if (seen || ie !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL rst_idle got hold_seen=%b ie=%b pending=%0d want 0 0 0", seen, ie, sb.size());
    end
  endtask
  initial begin
    test_reset();
    test_ie();
    test_single();
    test_priority();
    test_mask();
    test_fetch();
    test_nest();
    test_reset_take();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
